// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator.
package seq_comparator_pkg;

  // FSM state encoding
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = 1;
    while (v < value) begin
      v   = v << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational compare of one slice; optional sign handling on the top slice.
module chunk_compare #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_msb,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  // Flipping both sign bits maps two's-complement order onto unsigned order
  always_comb begin
    a_m            = a;
    b_m            = b;
    a_m[CHUNK-1]   = a[CHUNK-1] ^ signed_msb;
    b_m[CHUNK-1]   = b[CHUNK-1] ^ signed_msb;
    eq             = (a_m == b_m);
    gt             = (a_m >  b_m);
    lt             = (a_m <  b_m);
  end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle wide comparator: one slice per cycle, MSB slice first, early exit.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Gt,
  output logic             Sm
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

  logic [0:0]                   state, state_nxt;
  logic [IDX_W-1:0]             idx, idx_nxt;
  logic [NCHUNK-1:0][CHUNK-1:0] a_r, a_nxt;
  logic [NCHUNK-1:0][CHUNK-1:0] b_r, b_nxt;
  logic                         sgn_r, sgn_nxt;
  logic                         busy_nxt, done_nxt, eq_nxt, gt_nxt, sm_nxt;
  logic                         c_eq, c_gt, c_lt;
  logic                         top_slice;

  assign top_slice = (idx == IDX_W'(NCHUNK - 1));

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a          (a_r[idx]),
    .b          (b_r[idx]),
    .signed_msb (sgn_r & top_slice),
    .eq         (c_eq),
    .gt         (c_gt),
    .lt         (c_lt)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_nxt     = a_r;
    b_nxt     = b_r;
    sgn_nxt   = sgn_r;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    eq_nxt    = Eq;
    gt_nxt    = Gt;
    sm_nxt    = Sm;
    case (state)
      S_IDLE: begin
        if (start) begin
          a_nxt     = A;
          b_nxt     = B;
          sgn_nxt   = is_signed;
          idx_nxt   = IDX_W'(NCHUNK - 1);
          eq_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          sm_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (!c_eq) begin
          gt_nxt    = c_gt;
          sm_nxt    = c_lt;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (idx == '0) begin
          eq_nxt    = 1'b1;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx - IDX_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Eq    <= 1'b0;
      Gt    <= 1'b0;
      Sm    <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      a_r   <= a_nxt;
      b_r   <= b_nxt;
      sgn_r <= sgn_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      Eq    <= eq_nxt;
      Gt    <= gt_nxt;
      Sm    <= sm_nxt;
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (WIDTH=16, CHUNK=4).
module tb_seq_comparator;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sgn = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             busy, done, eq, gt, sm;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic m_busy = 1'b0, m_done = 1'b0, m_eq = 1'b0, m_gt = 1'b0, m_sm = 1'b0;
  logic p_eq, p_gt, p_sm;
  int   m_k = 0;

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (sgn),
    .A         (a_in),
    .B         (b_in),
    .busy      (busy),
    .done      (done),
    .Eq        (eq),
    .Gt        (gt),
    .Sm        (sm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from plain integer comparison; k = position (from MSB) of first differing slice
  function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s, output int k,
                                  output logic e, output logic g, output logic l);
    bit found;
    found = 0;
    k = NCHUNK;
    for (int i = 0; i < NCHUNK; i++) begin
      if (!found && (a[WIDTH-1-CHUNK*i -: CHUNK] != b[WIDTH-1-CHUNK*i -: CHUNK])) begin
        k = i + 1;
        found = 1;
      end
    end
    e = (a == b);
    if (s) begin
      g = ($signed(a) > $signed(b));
      l = ($signed(a) < $signed(b));
    end else begin
      g = (a > b);
      l = (a < b);
    end
  endfunction

  // Cycle model: latency counts down from the deciding slice position
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_eq = 0; m_gt = 0; m_sm = 0; m_k = 0;
    end else if (!m_busy && start) begin
      ref_cmp(a_in, b_in, sgn, m_k, p_eq, p_gt, p_sm);
      m_busy = 1; m_done = 0; m_eq = 0; m_gt = 0; m_sm = 0;
    end else if (m_busy) begin
      m_k--;
      if (m_k == 0) begin
        m_busy = 0; m_done = 1;
        m_eq = p_eq; m_gt = p_gt; m_sm = p_sm;
      end
    end else begin
      m_done = 0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("Eq",   int'(eq),   int'(m_eq));
    chk("Gt",   int'(gt),   int'(m_gt));
    chk("Sm",   int'(sm),   int'(m_sm));
  end

  task automatic run_case(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input int exp_lat,
                          input logic e, input logic g, input logic l);
    int lat;
    @(negedge clk);
    a_in = a; b_in = b; sgn = s; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (!done && lat < 20);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " Eq"}, int'(eq), int'(e));
    chk({nm, " Gt"}, int'(gt), int'(g));
    chk({nm, " Sm"}, int'(sm), int'(l));
  endtask

  task automatic pin_model(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic s, input int exp_k,
                           input logic e, input logic g, input logic l);
    int k; logic re, rg, rl;
    ref_cmp(a, b, s, k, re, rg, rl);
    chk({nm, " model k"}, k, exp_k);
    chk({nm, " model flags"}, int'({re, rg, rl}), int'({e, g, l}));
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;

    pin_model("m_eq",   16'h1234, 16'h1234, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    pin_model("m_sgn",  16'h8000, 16'h7FFF, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    pin_model("m_pos2", 16'h1300, 16'h1234, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    pin_model("m_neg",  16'hFFFF, 16'h0001, 1'b1, 1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset flags", int'({eq, gt, sm}), 0);
    rst = 1'b0;

    run_case("eq_u",     16'h1234, 16'h1234, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    run_case("msb_u",    16'h8000, 16'h7FFF, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    run_case("msb_s",    16'h8000, 16'h7FFF, 1'b1, 2, 1'b0, 1'b0, 1'b1);
    run_case("slice2",   16'h1300, 16'h1234, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    run_case("slice4",   16'h1233, 16'h1234, 1'b0, 5, 1'b0, 1'b0, 1'b1);
    run_case("s_ffff",   16'hFFFF, 16'hFFFF, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    run_case("s_neg1",   16'hFFFF, 16'h0001, 1'b1, 2, 1'b0, 1'b0, 1'b1);
    run_case("s_min",    16'h0000, 16'h8000, 1'b1, 2, 1'b0, 1'b1, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    a_in = 16'h0000; b_in = 16'h0000; sgn = 1'b0; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin start = 1'b1; a_in = 16'hFFFF; end
      else start = 1'b0;
    end while (!done && lat < 20);
    chk("busy_start latency", lat, 5);
    chk("busy_start Eq", int'(eq), 1);

    // Reset mid-compare
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h1234; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (lat < 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst flags", int'({eq, gt, sm}), 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst no done", int'(done), 0);
    end

    // Back-to-back: new start in the done cycle
    a_in = 16'h8000; b_in = 16'h7FFF; sgn = 1'b0; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (!done && lat < 20);
    chk("b2b first latency", lat, 2);
    chk("b2b first Gt", int'(gt), 1);
    a_in = 16'h1234; b_in = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b cleared", int'({eq, gt, sm}), 0);
    chk("b2b busy", int'(busy), 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b second latency", lat, 5);
    chk("b2b second Eq", int'(eq), 1);

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      @(negedge clk);
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: begin
          rb = ra;
          rb[CHUNK*$urandom_range(0, NCHUNK-1) +: CHUNK] = CHUNK'($urandom);
        end
        2: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH-1));
        default: rb = WIDTH'($urandom);
      endcase
      a_in  = ra;
      b_in  = rb;
      sgn   = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
